// File: rtl/widthadapt_pkg.sv
// Shared helpers for the width adapters: lane-index sizing and lane extraction.
// Used by both the 1-to-x packer and the x-to-1 unpacker.
package widthadapt_pkg;

    // Widest packed word any adapter instance may use.
    localparam int unsigned WA_MAX_WORD = 1024;

    // Lane-index width for a word of x lanes; never narrower than one bit.
    function automatic int unsigned lane_idx_w(input int unsigned x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

    // Returns lane idx (or its mirror when msb_first) in the low owidth bits.
    function automatic logic [WA_MAX_WORD-1:0] lane_sel(
        input logic [WA_MAX_WORD-1:0] word,
        input int unsigned            idx,
        input bit                     msb_first,
        input int unsigned            owidth,
        input int unsigned            x
    );
        int unsigned k;
        k = msb_first ? (x - 1 - idx) : idx;
        return word >> (k * owidth);
    endfunction

endpackage

// File: rtl/simple_widthadapt_x_to_1.sv
// Wide-word to narrow-beat unpacker with a current + prefetch word buffer.
// Define WIDTHADAPT_X_TO_1_PARTIAL_EN to add i_beats (short words).
module simple_widthadapt_x_to_1
    import widthadapt_pkg::*;
#(
    parameter  int p_owidth    = 16,
    parameter  int p_x         = 8,
    parameter  int p_msb_first = 0,
    localparam int p_iwidth    = p_owidth * p_x,
    localparam int p_xw        = $clog2(p_x)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [p_iwidth-1:0] i_data,
`ifdef WIDTHADAPT_X_TO_1_PARTIAL_EN
    input  logic [p_xw:0]       i_beats,
`endif
    output logic                o_ready,
    output logic                o_valid,
    output logic [p_owidth-1:0] o_data,
    output logic                o_last,
    input  logic                i_ready
);

    typedef logic [lane_idx_w(p_x)-1:0] lane_idx_t;

    if (p_x < 2 || (p_x & (p_x - 1)) != 0) begin : g_bad_x
        $error("p_x must be a power of two, at least 2");
    end
    if (p_iwidth > WA_MAX_WORD) begin : g_bad_w
        $error("input word wider than WA_MAX_WORD");
    end

    logic                r_cur_valid;
    logic                r_nxt_valid;
    lane_idx_t           r_idx;
    logic [p_iwidth-1:0] r_cur;
    logic [p_iwidth-1:0] r_nxt;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_last;
    logic                w_pop;
    lane_idx_t           w_cur_last;

`ifdef WIDTHADAPT_X_TO_1_PARTIAL_EN
    lane_idx_t           r_cur_last;
    lane_idx_t           r_nxt_last;
    lane_idx_t           w_in_last;

    // Zero or out-of-range counts mean a full word.
    always_comb begin
        w_in_last = lane_idx_t'(p_x - 1);
        if (i_beats != '0 && i_beats <= (p_xw + 1)'(p_x))
            w_in_last = lane_idx_t'(i_beats - 1'b1);
    end

    assign w_cur_last = r_cur_last;
`else
    assign w_cur_last = lane_idx_t'(p_x - 1);
`endif

    assign o_ready    = i_rst_n & ~r_nxt_valid;
    assign o_valid    = r_cur_valid;
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = r_cur_valid & i_ready;
    assign w_last     = r_cur_valid & (r_idx == w_cur_last);
    assign w_pop      = w_out_xfer & w_last;
    assign o_last     = w_last;
    assign o_data     = p_owidth'(lane_sel(WA_MAX_WORD'(r_cur), 32'(r_idx),
                                           p_msb_first != 0, p_owidth, p_x));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_idx       <= '0;
        end else begin
            if (w_out_xfer)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            // A last-beat pop refills from the prefetch slot, else from the input.
            if (w_pop) begin
                if (r_nxt_valid)
                    r_nxt_valid <= 1'b0;
                else if (!w_in_xfer)
                    r_cur_valid <= 1'b0;
            end else if (w_in_xfer) begin
                if (!r_cur_valid)
                    r_cur_valid <= 1'b1;
                else
                    r_nxt_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pop && r_nxt_valid) begin
            r_cur      <= r_nxt;
`ifdef WIDTHADAPT_X_TO_1_PARTIAL_EN
            r_cur_last <= r_nxt_last;
`endif
        end else if (w_in_xfer && (w_pop || !r_cur_valid)) begin
            r_cur      <= i_data;
`ifdef WIDTHADAPT_X_TO_1_PARTIAL_EN
            r_cur_last <= w_in_last;
`endif
        end else if (w_in_xfer) begin
            r_nxt      <= i_data;
`ifdef WIDTHADAPT_X_TO_1_PARTIAL_EN
            r_nxt_last <= w_in_last;
`endif
        end
    end

endmodule

// File: doc/simple_widthadapt_x_to_1.md
Name: simple_widthadapt_x_to_1

Overview:
- Downstream counterpart to the 1-to-x packer. It takes one wide word (p_x lanes of p_owidth bits) per handshake and emits the lanes one per beat on a narrow valid/ready stream.
- Used where packed SDRAM/BRAM read words are unpacked back into pixel/sample streams, e.g. feeding the display or scaler path.
- Two-word internal buffer (current + prefetch), so back-to-back words stream with no bubbles.

Parameters:
- p_owidth, 16, width of one narrow output lane in bits.
- p_x, 8, lanes per input word; powers of two only, minimum 2.
- p_msb_first, 0, 0 = lane 0 (bits [p_owidth-1:0]) emitted first; 1 = lane p_x-1 emitted first.
- p_iwidth (localparam), p_owidth*p_x, input word width.
- p_xw (localparam), $clog2(p_x), lane index width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input word valid.
- i_data  in  p_iwidth  packed input word; lane k at bits [k*p_owidth +: p_owidth].
- o_ready  out  1  block can accept a word this cycle.
- o_valid  out  1  output beat valid.
- o_data  out  p_owidth  current lane.
- o_last  out  1  high on the final beat of a word.
- i_ready  in  1  downstream accepts the beat.

Interface rule (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- State:
  - s_cur_valid and s_cur (word being serialized).
  - s_nxt_valid and s_nxt (prefetched word).
  - s_idx, p_xw bits: beat counter, 0..p_x-1.
- Reset (asynchronous on i_rst_n low): s_cur_valid=0, s_nxt_valid=0, s_idx=0.
  - Outputs during and right after reset: o_valid=0, o_last=0.
  - o_ready=0 while i_rst_n is low; o_ready=1 in the first cycle after release.
  - Data registers are not reset.
- Handshakes:
  - Input transfer = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
  - o_ready = i_rst_n & ~s_nxt_valid. It depends on registered state only; no combinational path from i_ready.
- Output decode:
  - o_valid = s_cur_valid.
  - o_data = lane(s_idx), or lane(p_x-1-s_idx) when p_msb_first=1.
  - o_last = s_cur_valid & (s_idx == beats-1).
  - o_data and o_last stay stable while o_valid & ~i_ready.
- Non-last output transfer: s_idx increments.
- Last output transfer: s_idx returns to 0, then exactly one of:
  - s_nxt_valid=1: s_cur<=s_nxt, s_nxt_valid<=0; if an input transfer also occurs, it cannot (o_ready=0).
  - s_nxt_valid=0 with an input transfer in the same cycle: input loads directly into s_cur, bypassing s_nxt; s_cur_valid stays 1.
  - Otherwise: s_cur_valid<=0.
- Input transfer, no last-beat pop in the same cycle:
  - s_cur_valid=0: load into s_cur.
  - s_cur_valid=1: load into s_nxt, s_nxt_valid<=1.
- Latency: first beat of an accepted word is valid the cycle after acceptance when the buffer is empty.
- Throughput: 1 beat/cycle sustained; at most 2 words buffered.
- i_valid & ~o_ready: word is held upstream, not dropped.
- Per-word beat count "beats" is p_x unless the optional feature is enabled.

Optional Feature:
- Macro: WIDTHADAPT_X_TO_1_PARTIAL_EN.
- When defined:
  - Adds input port i_beats, width p_xw+1: number of valid lanes in i_data.
  - i_beats is captured with the word into s_cur/s_nxt.
  - o_last asserts at beat i_beats-1; the remaining lanes are skipped.
  - i_beats=0 or i_beats>p_x is treated as p_x.
- When undefined: port absent, every word emits exactly p_x beats.

Decomposition:
- Shared package widthadapt_pkg holds:
  - a lane-index typedef sized from p_x via a parameterized function;
  - a lane-extract function lane_sel(word, idx, msb_first).
  - The 1-to-x packer reuses this package.
- No sub-module: the two-entry buffer and counter are small enough to stay in one module.

Test Plan (p_owidth=16, p_x=4):
- Single word, p_msb_first=0: 0x4444_3333_2222_1111, i_ready=1 -> o_valid one cycle after accept; beats 0x1111, 0x2222, 0x3333, 0x4444; o_last only on 0x4444; o_valid=0 afterwards.
- Three back-to-back words, i_valid and i_ready held high -> 12 consecutive beats with no gap; o_ready drops once s_nxt fills and rises on each last-beat pop.
- i_ready low for 5 cycles on beat 2 -> o_data=0x3333 and o_last=0 stable throughout; no beat lost or duplicated; a second word offered meanwhile is taken into s_nxt, then o_ready=0.
- i_rst_n pulsed low at beat 1 with s_nxt full -> o_valid=0 and o_ready=0 immediately (asynchronously); after release o_ready=1, o_valid=0, and no stale beats appear.
- p_msb_first=1, same word -> beats 0x4444, 0x3333, 0x2222, 0x1111.
- WIDTHADAPT_X_TO_1_PARTIAL_EN defined:
  - i_beats=2 -> beats 0x1111, 0x2222 with o_last on the second.
  - Next word with i_beats=0 -> 4 beats.
